// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the control unit and the iterative multiply/divide unit.
// Signal names follow the datapath schematic so they line up with the control unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    // Start/Done handshake:
    // - The unit samples Start, Op, A and B only while Busy=0.
    // - Busy stays high from the accepting edge until the result is written.
    // - Done is a one-cycle pulse. Start may be raised again in that same cycle.
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Abort;
    logic             WrHi;
    logic             WrLo;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A, B, Abort, WrHi, WrLo, WrData,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, Abort, WrHi, WrLo, WrData,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// It handles one bit per clock on operand magnitudes and applies the signs in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset,
    muldiv_unit_if.slave bus,
    output logic [1:0]   state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] hw_q, hw_d, lw_q, lw_d, opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_a_q, neg_a_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign signed_op = SIGNED_EN ? ~bus.Op[0] : 1'b0;
    assign a_neg     = signed_op & bus.A[WIDTH-1];
    assign b_neg     = signed_op & bus.B[WIDTH-1];
    assign a_mag     = a_neg ? -bus.A : bus.A;
    assign b_mag     = b_neg ? -bus.B : bus.B;

    // Multiply: the low word holds the multiplier and shifts right as product bits come in from the top.
    assign add_sum = {1'b0, hw_q} + (lw_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: the low word holds the dividend. Quotient bits shift in from the bottom.
    assign shifted = {hw_q, lw_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd_q};

    assign prod     = {hw_q, lw_q};
    assign prod_fix = neg_res_q ? -prod : prod;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hw_d      = hw_q;
        lw_d      = lw_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.WrHi) hi_d = bus.WrData;
                if (bus.WrLo) lo_d = bus.WrData;
                if (bus.Start) begin
                    if (bus.Op[1] && (bus.B == '0)) begin
                        done_d    = 1'b1;
                        divzero_d = 1'b1;
                    end else begin
                        is_div_d  = bus.Op[1];
                        neg_res_d = a_neg ^ b_neg;
                        neg_a_d   = a_neg;
                        hw_d      = '0;
                        lw_d      = bus.Op[1] ? a_mag : b_mag;
                        opnd_d    = bus.Op[1] ? b_mag : a_mag;
                        cnt_d     = '0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!diff[WIDTH]) begin
                            hw_d = diff[WIDTH-1:0];
                            lw_d = {lw_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hw_d = shifted[WIDTH-1:0];
                            lw_d = {lw_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hw_d = add_sum[WIDTH:1];
                        lw_d = {add_sum[0], lw_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.Abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = neg_res_q ? -lw_q : lw_q;
                        hi_d = neg_a_q ? -hw_q : hw_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            hw_q      <= '0;
            lw_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hw_q      <= hw_d;
            lw_q      <= lw_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = done_q;
    assign bus.DivZero = divzero_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, signed enabled).
// Expected results are hand-computed and queued in a scoreboard.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [1:0]   state_dbg;
    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.Done !== 1'b1 && lat < 200) begin
            if (bus.Busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_result(input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_hi"}, bus.Hi, exp_q.pop_front());
        check({tag, "_lo"}, bus.Lo, exp_q.pop_front());
    endtask

    task automatic write_hilo(input logic hi, input logic [W-1:0] data);
        bus.WrHi   = hi;
        bus.WrLo   = ~hi;
        bus.WrData = data;
        @(posedge clk); #1;
        bus.WrHi   = 1'b0;
        bus.WrLo   = 1'b0;
    endtask

    int lat, busy_n, done_seen;

    initial begin
        rst_n = 1'b0;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
        bus.Abort = 1'b0; bus.WrHi = 1'b0; bus.WrLo = 1'b0; bus.WrData = '0;
        #12;
        check("rst_hi", bus.Hi, 32'h0);
        check("rst_lo", bus.Lo, 32'h0);
        check("rst_busy", {31'b0, bus.Busy}, 32'h0);
        check("rst_done", {31'b0, bus.Done}, 32'h0);
        check("rst_divzero", {31'b0, bus.DivZero}, 32'h0);
        check("rst_state", {30'b0, state_dbg}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULT -3 * 7
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, busy_n);
        check("mult_latency", lat, 32'd33);
        check("mult_busy_cycles", busy_n, 32'd33);
        check("mult_divzero", {31'b0, bus.DivZero}, 32'h0);
        expect_result(32'hFFFF_FFFF, 32'hFFFF_FFEB);
        check_result("mult");
        @(posedge clk); #1;
        check("mult_done_pulse", {31'b0, bus.Done}, 32'h0);

        // MULTU max * max
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, busy_n);
        check("multu_latency", lat, 32'd33);
        expect_result(32'hFFFF_FFFE, 32'h0000_0001);
        check_result("multu");
        @(posedge clk); #1;

        // DIV -7 / 2, then DIVU 7 / 2 launched in the Done cycle
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, busy_n);
        check("div_latency", lat, 32'd33);
        expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_result("div");
        start_op(2'b11, 32'd7, 32'd2);
        check("b2b_busy", {31'b0, bus.Busy}, 32'h1);
        wait_done(lat, busy_n);
        check("divu_latency", lat, 32'd33);
        expect_result(32'd1, 32'd3);
        check_result("divu");
        @(posedge clk); #1;

        // direct writes, then divide by zero
        write_hilo(1'b1, 32'h1111_1111);
        write_hilo(1'b0, 32'h2222_2222);
        expect_result(32'h1111_1111, 32'h2222_2222);
        check_result("wr");
        start_op(2'b10, 32'd5, 32'd0);
        check("dz_done", {31'b0, bus.Done}, 32'h1);
        check("dz_flag", {31'b0, bus.DivZero}, 32'h1);
        check("dz_busy", {31'b0, bus.Busy}, 32'h0);
        expect_result(32'h1111_1111, 32'h2222_2222);
        check_result("dz");
        @(posedge clk); #1;
        check("dz_done_pulse", {31'b0, bus.Done}, 32'h0);
        check("dz_flag_pulse", {31'b0, bus.DivZero}, 32'h0);

        // signed overflow with Start/WrHi pulsed mid-CALC
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (5) begin @(posedge clk); #1; end
        bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd3; bus.B = 32'd3;
        bus.WrHi = 1'b1; bus.WrData = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.WrHi = 1'b0;
        check("ovf_hi_mid", bus.Hi, 32'h1111_1111);
        wait_done(lat, busy_n);
        check("ovf_latency", lat, 32'd27);
        expect_result(32'h0, 32'h8000_0000);
        check_result("ovf");
        @(posedge clk); #1;
        check("ovf_no_restart", {31'b0, bus.Busy}, 32'h0);

        // abort at iteration 10
        start_op(2'b00, 32'd6, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        bus.Abort = 1'b1;
        @(posedge clk); #1;
        bus.Abort = 1'b0;
        check("abort_busy", {31'b0, bus.Busy}, 32'h0);
        check("abort_state", {30'b0, state_dbg}, 32'h0);
        done_seen = 0;
        repeat (40) begin
            if (bus.Done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", done_seen, 32'd0);
        expect_result(32'h0, 32'h8000_0000);
        check_result("abort");

        // asynchronous reset at iteration 5
        start_op(2'b00, 32'd6, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.Busy}, 32'h0);
        expect_result(32'h0, 32'h0);
        check_result("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // unit still operates after reset
        start_op(2'b00, 32'd6, 32'd7);
        wait_done(lat, busy_n);
        check("post_latency", lat, 32'd33);
        expect_result(32'h0, 32'd42);
        check_result("post");

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with integrated HI/LO result registers.
- Replaces the separate mult and div blocks, the two HI/LO source muxes and the HIGH/LOW registers in the multicycle CPU datapath.
- Takes operands from the A/B registers, runs one shift-add or shift-subtract step per clock, and reports completion to the control unit via a start/done handshake.
- Also supports direct HI/LO writes (mthi/mtlo) and synchronous abort.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; legal range WIDTH >= 4.
- SIGNED_EN, 1: 1 = Op[0] selects signed/unsigned; 0 = all operations unsigned, Op[0] ignored.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  start request; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  multiplicand / dividend; sampled on the Start edge.
- B  input  WIDTH  multiplier / divisor; sampled on the Start edge.
- Abort  input  1  synchronous cancel of an operation in progress.
- WrHi  input  1  write WrData to HI; honoured in IDLE only.
- WrLo  input  1  write WrData to LO; honoured in IDLE only.
- WrData  input  WIDTH  data for WrHi/WrLo.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  one-cycle pulse, coincident with Done, on divide by zero.
- Hi  output  WIDTH  HI register (MULT upper half / DIV remainder).
- Lo  output  WIDTH  LO register (MULT lower half / DIV quotient).

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE.
  - Hi=Lo=0; Busy=Done=DivZero=0.
  - Iteration counter and internal working registers cleared.
  - An operation in progress is lost.
- States: IDLE, CALC, FIX. Done and DivZero are registered outputs, default 0 every cycle.
- IDLE:
  - On edge E with Start=1 and B!=0 or a MULT op:
    - Latch operand magnitudes; a signed op with a negative operand uses its two's-complement magnitude.
    - Latch result sign flags: product sign = signA XOR signB; quotient sign = signA XOR signB; remainder sign = signA.
    - counter=0; go to CALC.
  - Divide by zero (Start=1, Op=1x, B=0):
    - Stay in IDLE; Hi/Lo unchanged.
    - Done=1 and DivZero=1 for the cycle after E.
  - WrHi/WrLo with Start=0: write WrData to HI/LO at the edge.
  - WrHi/WrLo with Start=1: write still applies; the operation's result later overwrites it.
- CALC:
  - One iteration per edge, WIDTH iterations total, edges E+1..E+WIDTH.
  - Multiply: 2*WIDTH-bit shift-add, unsigned magnitudes.
  - Divide: restoring shift-subtract, unsigned magnitudes, truncating quotient.
  - After iteration WIDTH, go to FIX.
  - Start, WrHi, WrLo are ignored while Busy=1.
- FIX (edge E+WIDTH+1):
  - Apply the sign flags (two's-complement negate where set).
  - Multiply: Hi = product[2W-1:W], Lo = product[W-1:0].
  - Divide: Lo = quotient, Hi = remainder.
  - Done=1 for the cycle after E+WIDTH+1; state=IDLE.
  - Total latency: Done asserted WIDTH+1 edges after the Start edge.
- Signed overflow: DIV of most-negative by -1 gives Lo = most-negative (wrap) and Hi = 0; no flag.
- Abort=1 in CALC or FIX:
  - Go to IDLE at that edge; Hi/Lo unchanged; no Done.
  - Abort in IDLE has no effect.
  - Abort has priority over FIX completion.
- Back-to-back operation: Start may be asserted in the cycle Done=1 (state is IDLE) and is accepted.
- Hi/Lo change only on: reset, FIX, or an honoured WrHi/WrLo.

Test Plan (WIDTH=32, SIGNED_EN=1):
- MULT A=0xFFFFFFFD (-3), B=7 -> after 33 edges Done=1 for one cycle; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; then DIVU 7/2 issued in the Done cycle -> Lo=3, Hi=1.
- WrHi 0x11111111 and WrLo 0x22222222, then DIV A=5, B=0 -> Done=DivZero=1 one cycle after Start; Hi/Lo unchanged; Busy never asserted.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; Start/WrHi pulsed mid-CALC are ignored.
- MULT 6*7 with Abort at iteration 10 -> IDLE, no Done, Hi/Lo keep prior values; then MULT with Reset=0 at iteration 5 -> Hi=Lo=0, Busy=0 immediately, without waiting for a clock edge.
